// File: rtl/serneg_arbiter.sv
// Round-robin two-requester front end for a bit-serial two's-complement negation engine.
// Optional overflow flag (out_ovf) is present only when SERNEG_OVF_EN is defined.
//
// state | meaning
// IDLE  | arbitrating; a granted requester's word is loaded on the accept edge
// SHIFT | one operand bit per edge, LSB first, copy-until-first-one then invert
// DONE  | result held on out_data/out_id until out_ready
module serneg_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  input  logic             out_ready,
`ifdef SERNEG_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             seen_q;
  logic             last_q;
  logic             id_q;
  logic             valid_q;
`ifdef SERNEG_OVF_EN
  logic             ovf_q;
`endif

  logic gnt_vld;
  logic gnt_id;
  logic bit_in;
  logic bit_out;

  // With both requesting, the one not served last time wins.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
  end

  assign req0_ready = (state_q == IDLE) && gnt_vld && !gnt_id;
  assign req1_ready = (state_q == IDLE) && gnt_vld &&  gnt_id;

  assign bit_in  = op_q[0];
  assign bit_out = seen_q ? ~bit_in : bit_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      valid_q <= 1'b0;
`ifdef SERNEG_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            op_q    <= gnt_id ? req1_data : req0_data;
            id_q    <= gnt_id;
            last_q  <= gnt_id;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Result bits enter at the top so the LSB lands in bit 0 after WIDTH edges.
          res_q  <= {bit_out, res_q[WIDTH-1:1]};
          op_q   <= op_q >> 1;
          seen_q <= seen_q | bit_in;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            valid_q <= 1'b1;
`ifdef SERNEG_OVF_EN
            ovf_q   <= bit_in & ~seen_q;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
`ifdef SERNEG_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_data  = res_q;
  assign out_id    = id_q;
  assign busy      = (state_q != IDLE);
`ifdef SERNEG_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: doc/serneg_arbiter.md
# serneg_arbiter

Two-requester front end for the shared bit-serial two's-complement negation engine. Arbitrates round-robin between two parallel word requesters with valid/ready handshakes and loads the granted word into a shift register. Drives it LSB-first through the copy-until-first-one / invert-thereafter Mealy rule, reassembles the result, and returns it with the winning requester's ID. Sits between the parallel datapath clients and the serial arithmetic resource so one engine is time-shared.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- req0_valid  input  1  requester 0 has a word
- req0_data  input  WIDTH  requester 0 operand
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid  input  1  requester 1 has a word
- req1_data  input  WIDTH  requester 1 operand
- req1_ready  output  1  requester 1 word accepted this cycle
- out_valid  output  1  result available
- out_data  output  WIDTH  negated operand (two's complement, mod 2^WIDTH)
- out_id  output  1  requester that owns out_data
- out_ready  input  1  consumer takes result
- busy  output  1  state ≠ IDLE
- out_ovf  output  1  operand was −2^(WIDTH−1) (only with SERNEG_OVF_EN)

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE, shift reg 0, bit counter 0, seen-one flag 0, last-grant pointer = 1 (req0 wins first), all outputs 0.
- IDLE: grant = sole valid requester; if both valid, the one ≠ last-grant. reqN_ready = (state==IDLE) && grant==N, combinational, one cycle only. On accept edge: load data, out_id = N, last-grant = N, counter = 0, seen = 0 → SHIFT.
- SHIFT: per edge process bit[counter] (LSB first): result bit = seen ? ~b : b; seen |= b; counter++. After the bit WIDTH−1 edge → DONE.
- DONE: out_valid=1; out_data/out_id/out_ovf stable until out_ready. Edge with out_ready=1 → IDLE, out_valid drops.
- reqN_ready is 0 in SHIFT and DONE; requesters hold valid/data until ready. Data changing before accept is legal; only the accepted-edge value is used.
- Arithmetic: 0 → 0; −2^(WIDTH−1) → itself (wraps).
- No requests in IDLE: remain IDLE, pointer unchanged.

## Timing
- Accept at edge T; out_valid high after edge T+WIDTH (WIDTH SHIFT edges).
- Minimum issue interval WIDTH+2 cycles (accept, WIDTH shifts, DONE with out_ready=1; next accept on following IDLE cycle).
- out_ready held low: stays in DONE indefinitely, no new accept.
- out_ready high before out_valid: ignored.
- rst asserted any time (incl. mid-SHIFT or DONE): immediately IDLE, out_valid=0, partial result discarded, pointer = 1; no response for the lost word.
- busy rises after the accept edge, falls after the DONE→IDLE edge.

## Configuration
- SERNEG_OVF_EN defined: out_ovf port present; set in DONE when the operand MSB=1 and all lower bits 0 (seen==0 when MSB processed, MSB=1); cleared in IDLE and by reset.
- Not defined: out_ovf port and its logic absent; all other behaviour identical.

## Test plan
- WIDTH=8, req0 0x01 alone → req0_ready 1 cycle, out_valid 8 edges later, out_data 0xFF, out_id 0.
- req1 0x00 → out_data 0x00, out_id 1; req0 0x80 → out_data 0x80, out_ovf 1 with SERNEG_OVF_EN (port absent without).
- Both valid from reset, req0 0x05, req1 0x0C, held until ready → 0xFB id 0 then 0xF4 id 1; both re-presented → req0 next (alternation).
- Result 0xB4 (operand 0x4C) with out_ready low 5 cycles → out_data/out_id held, reqN_ready 0 throughout; accept resumes cycle after out_ready.
- rst pulse low after 3 SHIFT edges → out_valid 0, busy 0 immediately; next concurrent request granted to req0, correct result.
- Back-to-back req0 stream, out_ready tied 1 → one accept every 10 cycles, results 2's complement of each input.
